// File: rtl/otter_div_unit.sv
// Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Radix-2 restoring division, one quotient bit per cycle, valid/ready result handshake.
module otter_div_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out
);

  typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [XLEN-1:0]  out_q, out_d;

  // Request decode; op[0]=0 selects the signed variants
  logic            accept;
  logic            is_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, ovf, special;

  assign accept    = (state_q == StIdle) && in_valid && !flush;
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[XLEN-1];
  assign b_neg     = is_signed & b[XLEN-1];
  assign abs_a     = a_neg ? (~a + 1'b1) : a;
  assign abs_b     = b_neg ? (~b + 1'b1) : b;
  assign div_zero  = (b == '0);
  assign ovf       = is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign special   = div_zero | ovf;

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign rem_sh  = {rem_q, quo_q[XLEN-1]};
  assign diff    = rem_sh - {1'b0, dvs_q};
  assign quo_fix = qneg_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = rneg_q ? (~rem_q + 1'b1) : rem_q;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (in_valid) state_d = special ? StDone : StBusy;
        StBusy: if (cnt_q == '0) state_d = StFix;
        StFix:  state_d = StDone;
        StDone: if (out_ready) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    out       = out_q;
  end

  // Datapath next-state
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    out_d  = out_q;
    if (accept) begin
      op_d   = op;
      cnt_d  = CNT_W'(XLEN - 1);
      rem_d  = '0;
      quo_d  = abs_a;
      dvs_d  = abs_b;
      qneg_d = a_neg ^ b_neg;
      rneg_d = a_neg;
      if (div_zero) begin
        out_d = op[1] ? a : '1;
      end else if (ovf) begin
        out_d = op[1] ? '0 : a;
      end
    end else if (!flush && (state_q == StBusy)) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (!diff[XLEN]) begin
        rem_d = diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
    end else if (!flush && (state_q == StFix)) begin
      out_d = op_q[1] ? rem_fix : quo_fix;
    end
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      op_q   <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      out_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      out_q  <= out_d;
    end
  end

endmodule

// File: tb/tb_otter_div_unit.sv
// Directed bench for otter_div_unit: results, latency, backpressure, flush and async reset.
module tb_otter_div_unit;

  localparam int LatNorm = 34;  // out_valid sampled high at edge E0+XLEN+2
  localparam int LatSpec = 1;   // special cases: sampled high at edge E0+1

  localparam logic [1:0] OpDiv  = 2'b00;
  localparam logic [1:0] OpDivu = 2'b01;
  localparam logic [1:0] OpRem  = 2'b10;
  localparam logic [1:0] OpRemu = 2'b11;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;

  int n_tests = 0;
  int n_fail  = 0;
  logic seen;

  otter_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .CLK(CLK),
    .RST(RST),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the first negedge after the accept edge,
  // with op/a/b scrambled to show they are not re-sampled.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    op = ~o;
    a = $urandom;
    b = $urandom;
  endtask

  // lat = index of the edge after E0 at which a consumer first samples out_valid=1
  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge CLK);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic consume(input string tag, input logic [31:0] exp);
    check({tag, " out"}, out, exp);
    check({tag, " in_ready in DONE"}, {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    check({tag, " out_valid after take"}, {31'b0, out_valid}, 32'd0);
    check({tag, " in_ready after take"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    issue(o, x, y);
    wait_done(tag, exp_lat);
    consume(tag, exp);
  endtask

  initial begin
    // Reset state
    #12;
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset out", out, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("post-reset in_ready", {31'b0, in_ready}, 32'd1);

    // Normal divisions
    run("DIV -7/2",   OpDiv,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LatNorm);
    run("REM -7/2",   OpRem,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LatNorm);
    run("DIVU F9/2",  OpDivu, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, LatNorm);
    run("REMU 100/7", OpRemu, 32'd100, 32'd7, 32'd2, LatNorm);
    run("DIV 100/-7", OpDiv,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, LatNorm);
    run("REM -100/7", OpRem,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, LatNorm);

    // Divide by zero and signed overflow
    run("DIV x/0",    OpDiv,  32'h0000_1234, 32'd0, 32'hFFFF_FFFF, LatSpec);
    run("REMU x/0",   OpRemu, 32'h0000_1234, 32'd0, 32'h0000_1234, LatSpec);
    run("REM -7/0",   OpRem,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, LatSpec);
    run("DIV ovf",    OpDiv,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LatSpec);
    run("REM ovf",    OpRem,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LatSpec);

    // Backpressure: result held while out_ready=0; in_valid in DONE is ignored
    issue(OpDivu, 32'd100, 32'd7);
    wait_done("bp", LatNorm);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      op = OpDiv;
      a = 32'd5;
      b = 32'd0;
      check("bp out", out, 32'd14);
      check("bp out_valid", {31'b0, out_valid}, 32'd1);
      check("bp in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge CLK);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    check("bp idle in_ready", {31'b0, in_ready}, 32'd1);
    check("bp idle out_valid", {31'b0, out_valid}, 32'd0);

    // Flush mid-BUSY
    issue(OpRemu, 32'd100, 32'd7);
    repeat (14) @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    check("flush in_ready", {31'b0, in_ready}, 32'd1);
    check("flush out kept", out, 32'd14);
    seen = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      if (out_valid) seen = 1'b1;
    end
    check("flush no out_valid", {31'b0, seen}, 32'd0);
    run("DIVU after flush", OpDivu, 32'd100, 32'd7, 32'd14, LatNorm);

    // Flush beats in_valid in IDLE
    flush = 1'b1;
    in_valid = 1'b1;
    op = OpDiv;
    a = 32'd8;
    b = 32'd0;
    @(negedge CLK);
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    check("flush+req in_ready", {31'b0, in_ready}, 32'd1);
    check("flush+req out_valid", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset mid-BUSY
    issue(OpDivu, 32'hFFFF_FFF9, 32'd2);
    repeat (10) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    check("async rst out_valid", {31'b0, out_valid}, 32'd0);
    check("async rst out", out, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("rst release in_ready", {31'b0, in_ready}, 32'd1);
    run("DIV after reset", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LatNorm);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
